// File: rtl/fir_sequencer.sv
// Micro-op sequencer for the shared FIR register file / ALU datapath.
// Converts data_ready / load_coeff requests into coefficient loads and a 12-cycle sample MAC.
module fir_sequencer #(
  parameter int OP_W   = 3,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              data_ready,
  input  logic              load_coeff,
  input  logic              overflow,
  output logic [OP_W-1:0]   op,
  output logic [ADDR_W-1:0] src1,
  output logic [ADDR_W-1:0] src2,
  output logic [ADDR_W-1:0] dest,
  output logic              cnt_up,
  output logic              modwait,
  output logic              err
);

  localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_COPY  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LDSMP = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LDCOF = OP_W'(3);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MUL   = OP_W'(6);

  typedef enum logic [3:0] {
    IDLE, LOADC, WAITC, STORE, SH3, SH2, SH1, SH0,
    MUL0, MUL1, SUB1, MUL2, ADD2, MUL3, SUB3, EIDLE
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       modwait_q, modwait_d;
  logic       err_q, err_d;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      modwait_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      modwait_q <= modwait_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE, EIDLE: begin
        if (load_coeff)      state_d = LOADC;
        else if (data_ready) state_d = STORE;
      end
      LOADC: state_d = WAITC;
      WAITC: begin
        if (!load_coeff) begin
          state_d = IDLE;
          idx_d   = idx_q + 2'd1;
        end
      end
      // a request that drops before the store cycle is a protocol error
      STORE: state_d = data_ready ? SH3 : EIDLE;
      SH3:   state_d = SH2;
      SH2:   state_d = SH1;
      SH1:   state_d = SH0;
      SH0:   state_d = MUL0;
      MUL0:  state_d = MUL1;
      MUL1:  state_d = SUB1;
      SUB1:  state_d = overflow ? EIDLE : MUL2;
      MUL2:  state_d = ADD2;
      ADD2:  state_d = overflow ? EIDLE : MUL3;
      MUL3:  state_d = SUB3;
      SUB3:  state_d = overflow ? EIDLE : IDLE;
      default: state_d = IDLE;
    endcase
    // flags are registered from the next state so they align with the state register
    modwait_d = !(state_d inside {IDLE, WAITC, EIDLE});
    err_d     = (state_d == EIDLE);
  end

  always_comb begin
    op     = OP_NOP;
    src1   = '0;
    src2   = '0;
    dest   = '0;
    cnt_up = 1'b0;
    case (state_q)
      LOADC: begin op = OP_LDCOF; dest = ADDR_W'(6) + ADDR_W'(idx_q); end
      STORE: begin op = OP_LDSMP; dest = ADDR_W'(1); cnt_up = 1'b1; end
      SH3:   begin op = OP_COPY; src1 = ADDR_W'(4); dest = ADDR_W'(5); end
      SH2:   begin op = OP_COPY; src1 = ADDR_W'(3); dest = ADDR_W'(4); end
      SH1:   begin op = OP_COPY; src1 = ADDR_W'(2); dest = ADDR_W'(3); end
      SH0:   begin op = OP_COPY; src1 = ADDR_W'(1); dest = ADDR_W'(2); end
      MUL0:  begin op = OP_MUL; src1 = ADDR_W'(2); src2 = ADDR_W'(6); dest = ADDR_W'(0); end
      MUL1:  begin op = OP_MUL; src1 = ADDR_W'(3); src2 = ADDR_W'(7); dest = ADDR_W'(10); end
      SUB1:  begin op = OP_SUB; src1 = ADDR_W'(0); src2 = ADDR_W'(10); dest = ADDR_W'(0); end
      MUL2:  begin op = OP_MUL; src1 = ADDR_W'(4); src2 = ADDR_W'(8); dest = ADDR_W'(10); end
      ADD2:  begin op = OP_ADD; src1 = ADDR_W'(0); src2 = ADDR_W'(10); dest = ADDR_W'(0); end
      MUL3:  begin op = OP_MUL; src1 = ADDR_W'(5); src2 = ADDR_W'(9); dest = ADDR_W'(10); end
      SUB3:  begin op = OP_SUB; src1 = ADDR_W'(0); src2 = ADDR_W'(10); dest = ADDR_W'(0); end
      default: ;
    endcase
  end

  assign modwait = modwait_q;
  assign err     = err_q;

endmodule

// File: tb/tb_fir_sequencer.sv
// Bench for fir_sequencer: directed scenarios then random traffic, checked every cycle
// against a table-driven behavioural model of the micro-op program.
module tb_fir_sequencer;
  logic       clk = 1'b0;
  logic       n_reset, data_ready, load_coeff, overflow;
  logic [2:0] op;
  logic [3:0] src1, src2, dest;
  logic       cnt_up, modwait, err;

  fir_sequencer #(.OP_W(3), .ADDR_W(4)) dut (
    .clk(clk), .n_reset(n_reset), .data_ready(data_ready), .load_coeff(load_coeff),
    .overflow(overflow), .op(op), .src1(src1), .src2(src2), .dest(dest),
    .cnt_up(cnt_up), .modwait(modwait), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model: mode + position in the 12-step sample program
  localparam int M_IDLE = 0, M_LOADC = 1, M_WAITC = 2, M_SEQ = 3, M_EIDLE = 4;
  int m_mode = M_IDLE;
  int m_step = 0;
  int m_idx  = 0;

  int op_tab [12] = '{2, 1, 1, 1, 1, 6, 6, 5, 6, 4, 6, 5};
  int s1_tab [12] = '{0, 4, 3, 2, 1, 2, 3, 0, 4, 0, 5, 0};
  int s2_tab [12] = '{0, 0, 0, 0, 0, 6, 7, 10, 8, 10, 9, 10};
  int dst_tab[12] = '{1, 5, 4, 3, 2, 0, 10, 0, 10, 0, 10, 0};

  int mw_cnt, cu_cnt, copy_cnt, ldc_cnt, last_ldc_dest;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] model_out();
    int o = 0, a = 0, b = 0, d = 0, cu = 0, mw = 0, e = 0;
    case (m_mode)
      M_LOADC: begin o = 3; d = 6 + m_idx; mw = 1; end
      M_SEQ: begin
        o = op_tab[m_step]; a = s1_tab[m_step]; b = s2_tab[m_step];
        d = dst_tab[m_step]; cu = (m_step == 0); mw = 1;
      end
      M_EIDLE: e = 1;
      default: ;
    endcase
    return {o[2:0], a[3:0], b[3:0], d[3:0], cu[0], mw[0], e[0]};
  endfunction

  function automatic void model_step(input logic dr, input logic lc, input logic ov, input logic rst);
    if (!rst) begin
      m_mode = M_IDLE; m_idx = 0;
      return;
    end
    case (m_mode)
      M_IDLE, M_EIDLE: begin
        if (lc) m_mode = M_LOADC;
        else if (dr) begin m_mode = M_SEQ; m_step = 0; end
      end
      M_LOADC: m_mode = M_WAITC;
      M_WAITC: if (!lc) begin m_mode = M_IDLE; m_idx = (m_idx + 1) % 4; end
      default: begin
        if (m_step == 0 && !dr) m_mode = M_EIDLE;
        else if (ov && op_tab[m_step] inside {4, 5}) m_mode = M_EIDLE;
        else if (m_step == 11) m_mode = M_IDLE;
        else m_step++;
      end
    endcase
  endfunction

  // one clock: drive, check at negedge, advance model at posedge
  task automatic cyc(input logic dr, input logic lc, input logic ov, input logic rst);
    data_ready = dr; load_coeff = lc; overflow = ov; n_reset = rst;
    @(negedge clk);
    chk("outputs", {14'd0, op, src1, src2, dest, cnt_up, modwait, err}, {14'd0, model_out()});
    if (modwait) mw_cnt++;
    if (cnt_up) cu_cnt++;
    if (op == 3'd1) copy_cnt++;
    if (op == 3'd3) begin ldc_cnt++; last_ldc_dest = int'(dest); end
    @(posedge clk);
    model_step(dr, lc, ov, rst);
    #1;
  endtask

  task automatic clr_cnt();
    mw_cnt = 0; cu_cnt = 0; copy_cnt = 0; ldc_cnt = 0; last_ldc_dest = -1;
  endtask

  // request a sample; optionally raise overflow or assert reset at a given program step
  task automatic run_sample(input int ov_step, input int rst_step);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 14 && m_mode == M_SEQ; k++)
      cyc(m_step == 0, 1'b0, m_step == ov_step, m_step != rst_step);
  endtask

  initial begin
    int exp_dest;
    clr_cnt();
    data_ready = 1'b1; load_coeff = 1'b0; overflow = 1'b0; n_reset = 1'b0;
    @(posedge clk); model_step(1'b1, 1'b0, 1'b0, 1'b0); #1;

    // reset held with data_ready high
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_modwait", mw_cnt, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // five coefficient loads, the fifth wraps back to R6
    for (int p = 0; p < 5; p++) begin
      clr_cnt();
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, (p % 2) == 1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      exp_dest = 6 + (p % 4);
      chk("coeff_dest", last_ldc_dest, exp_dest);
      chk("coeff_modwait_cycles", mw_cnt, 1);
    end

    // normal sample
    clr_cnt();
    run_sample(-1, -1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("sample_modwait_cycles", mw_cnt, 12);
    chk("sample_cnt_up", cu_cnt, 1);
    chk("sample_copies", copy_cnt, 4);
    chk("sample_err", err, 1'b0);

    // overflow during SUB1
    clr_cnt();
    run_sample(7, -1);
    chk("ovf_err", err, 1'b1);
    chk("ovf_modwait", modwait, 1'b0);
    chk("ovf_op", op, 3'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("recover_err", err, 1'b0);
    for (int k = 0; k < 13 && m_mode == M_SEQ; k++) cyc(m_step == 0, 1'b0, 1'b0, 1'b1);

    // protocol error: request drops before STORE completes
    clr_cnt();
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("proto_err", err, 1'b1);
    chk("proto_cnt_up", cu_cnt, 1);
    chk("proto_copies", copy_cnt, 0);

    // reset during MUL2
    run_sample(-1, 8);
    chk("midrst_modwait", modwait, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // simultaneous requests: coefficient load wins
    clr_cnt();
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("prio_loadc", ldc_cnt, 1);
    chk("prio_dest", last_ldc_dest, 6);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // random traffic
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 25, $urandom_range(0, 99) >= 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
